// File: rtl/br_lite_inject.sv
// BrLite local-port injection stage: buffers PE broadcast requests,
// allocates flit ids and drives the router through req/ack.
package br_lite_pkg;
   typedef enum logic [1:0] {
      BR_SVC_ALL   = 2'd0,
      BR_SVC_TGT   = 2'd1,
      BR_SVC_MON   = 2'd2,
      BR_SVC_CLEAR = 2'd3
   } br_svc_t;

   typedef struct packed {
      br_svc_t     service;
      logic [4:0]  id;
      logic [7:0]  ksvc;
      logic [15:0] producer;
      logic [15:0] seq_source;
      logic [15:0] seq_target;
      logic [31:0] payload;
   } br_data_t;
endpackage

module br_lite_inject
   import br_lite_pkg::*;
#(
   parameter logic [15:0] ADDRESS     = 16'h0000,
   parameter int          BUFFER_SIZE = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   input  logic [1:0]  tx_svc_i,
   input  logic [7:0]  tx_ksvc_i,
   input  logic [15:0] tx_producer_i,
   input  logic [15:0] tx_target_i,
   input  logic [31:0] tx_payload_i,
   output logic        tx_err_o,
   output logic        req_o,
   input  logic        ack_i,
   output br_data_t    data_o,
   input  logic        done_i,
   input  logic [4:0]  done_id_i,
   output logic [31:0] busy_o
);
   localparam int AW = $clog2(BUFFER_SIZE);

   typedef struct packed {
      br_svc_t     svc;
      logic [7:0]  ksvc;
      logic [15:0] producer;
      logic [15:0] target;
      logic [31:0] payload;
   } entry_t;

   typedef enum logic {IDLE, SEND} state_t;

   entry_t      mem_q [BUFFER_SIZE];
   entry_t      head;
   logic [AW:0] wr_q, rd_q;
   logic        full, empty, push, pop;
   br_svc_t     in_svc;
   logic        err_q, err_d;
   state_t      state_q, state_d;
   br_data_t    data_q, data_d;
   logic [31:0] busy_q, busy_d;
   logic [4:0]  next_id_q, next_id_d;
   logic [4:0]  free_id, id_sel;
   logic        found, load, ack_ev;

   assign in_svc = br_svc_t'(tx_svc_i);
   assign empty  = (wr_q == rd_q);
   assign full   = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign push   = tx_valid_i && !full && (in_svc != BR_SVC_CLEAR);
   assign err_d  = tx_valid_i && !full && (in_svc == BR_SVC_CLEAR);
   assign head   = mem_q[rd_q[AW-1:0]];

   assign tx_ready_o = !full;
   assign tx_err_o   = err_q;
   assign data_o     = data_q;
   assign busy_o     = busy_q;

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q[AW-1:0]] <= {in_svc, tx_ksvc_i, tx_producer_i,
                                        tx_target_i, tx_payload_i};
   end

   // Rotating search: lowest offset from next_id wins, so scan downwards.
   always_comb begin
      found   = 1'b0;
      free_id = '0;
      for (int i = 31; i >= 0; i--) begin
         if (!busy_q[next_id_q + 5'(i)]) begin
            found   = 1'b1;
            free_id = next_id_q + 5'(i);
         end
      end
   end

   assign id_sel = (head.svc == BR_SVC_MON) ? next_id_q : free_id;
   assign load   = (state_q == IDLE) && !empty &&
                   ((head.svc == BR_SVC_MON) || found);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         wr_q      <= '0;
         rd_q      <= '0;
         err_q     <= 1'b0;
         data_q    <= '0;
         busy_q    <= '0;
         next_id_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_q + (AW+1)'(push);
         rd_q      <= rd_q + (AW+1)'(pop);
         err_q     <= err_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         next_id_q <= next_id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (load)  state_d = SEND;
         SEND:    if (ack_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_o  = (state_q == SEND);
      ack_ev = (state_q == SEND) && ack_i;
      pop    = ack_ev;
   end

   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d.service    = head.svc;
         data_d.id         = id_sel;
         data_d.ksvc       = head.ksvc;
         data_d.producer   = head.producer;
         data_d.seq_source = ADDRESS;
         data_d.seq_target = (head.svc == BR_SVC_TGT) ? head.target
                                                      : 16'hFFFF;
         data_d.payload    = head.payload;
      end
   end

   // A done and a reserving ack on the same cycle both take effect.
   always_comb begin
      busy_d    = busy_q;
      next_id_d = next_id_q;
      if (done_i) busy_d[done_id_i] = 1'b0;
      if (ack_ev) begin
         if (data_q.service inside {BR_SVC_ALL, BR_SVC_TGT})
            busy_d[data_q.id] = 1'b1;
         next_id_d = data_q.id + 5'd1;
      end
   end
endmodule
